// File: rtl/collision_event_filter_pkg.sv
// defines: shared constants and channel indices for the collision event filter.
package defines;
    localparam int COLLISION_COOLDOWN_FRAMES = 8;
    localparam int NUM_CHANNELS = 3;
    typedef enum logic [1:0] {CH_OBST = 2'd0, CH_BOTTOM = 2'd1, CH_CREDIT = 2'd2} channel_e;
endpackage

// File: rtl/collision_event_filter_channel.sv
// collision_channel: per-channel frame latch, previous-frame flag and re-trigger cooldown.
module collision_channel
    import defines::*;
#(
    parameter int COOLDOWN_FRAMES = COLLISION_COOLDOWN_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic pause,
    input  logic flush,
    input  logic raw,
    output logic fire
);
    logic       hit_q, hit_d;
    logic       prev_q, prev_d;
    logic [3:0] cooldown_q, cooldown_d;

    // Raw data seen in the boundary cycle already belongs to the new frame.
    always_comb begin
        fire       = startOfFrame && !flush && !pause && hit_q && !prev_q && cooldown_q == 4'd0;
        hit_d      = (flush || pause) ? 1'b0 : startOfFrame ? raw : (hit_q | raw);
        prev_d     = flush ? 1'b0 : startOfFrame ? (hit_q && !pause) : prev_q;
        cooldown_d = flush ? 4'd0 :
                     !startOfFrame ? cooldown_q :
                     fire ? 4'(COOLDOWN_FRAMES) :
                     cooldown_q - {3'd0, cooldown_q != 4'd0};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_q      <= 1'b0;
            prev_q     <= 1'b0;
            cooldown_q <= 4'd0;
        end else begin
            hit_q      <= hit_d;
            prev_q     <= prev_d;
            cooldown_q <= cooldown_d;
        end
    end
endmodule

// File: rtl/collision_event_filter.sv
// collision_event_filter: collapses pixel-level collision flags into one-shot,
// frame-aligned, cooldown-limited event pulses for the game controller.
module collision_event_filter
    import defines::*;
#(
    parameter int COOLDOWN_FRAMES = COLLISION_COOLDOWN_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic pause,
    input  logic reset_level_pulse,
    input  logic rawBallObstacle,
    input  logic rawObstacleGood,
    input  logic rawObstacleBad,
    input  logic rawBallBottom,
    input  logic rawBallCredit,
    output logic collisionBallObstacle,
    output logic collisionBallObstacleGood,
    output logic collisionBallObstacleBad,
    output logic collisionBallBottom,
    output logic collisionBallCredit
);
    logic [NUM_CHANNELS-1:0] raw_ch, fire_ch;
    logic good_q, good_d, bad_q, bad_d;
    logic obst_q, obst_d, obst_good_q, obst_good_d, obst_bad_q, obst_bad_d;
    logic bottom_q, bottom_d, credit_q, credit_d;
    logic good_raw, bad_raw;

    assign raw_ch = {rawBallCredit, rawBallBottom, rawBallObstacle};

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_ch (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .pause        (pause),
            .flush        (reset_level_pulse),
            .raw          (raw_ch[g]),
            .fire         (fire_ch[g])
        );
    end

    // Qualifiers only count while the ball actually overlaps an obstacle.
    always_comb begin
        good_raw    = rawBallObstacle & rawObstacleGood;
        bad_raw     = rawBallObstacle & rawObstacleBad;
        good_d      = (reset_level_pulse || pause) ? 1'b0 : startOfFrame ? good_raw : (good_q | good_raw);
        bad_d       = (reset_level_pulse || pause) ? 1'b0 : startOfFrame ? bad_raw : (bad_q | bad_raw);
        obst_d      = fire_ch[CH_OBST];
        obst_good_d = fire_ch[CH_OBST] & good_q;
        obst_bad_d  = fire_ch[CH_OBST] & bad_q;
        bottom_d    = fire_ch[CH_BOTTOM];
        credit_d    = fire_ch[CH_CREDIT];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            obst_q      <= 1'b0;
            obst_good_q <= 1'b0;
            obst_bad_q  <= 1'b0;
            bottom_q    <= 1'b0;
            credit_q    <= 1'b0;
        end else begin
            good_q      <= good_d;
            bad_q       <= bad_d;
            obst_q      <= obst_d;
            obst_good_q <= obst_good_d;
            obst_bad_q  <= obst_bad_d;
            bottom_q    <= bottom_d;
            credit_q    <= credit_d;
        end
    end

    assign collisionBallObstacle     = obst_q;
    assign collisionBallObstacleGood = obst_good_q;
    assign collisionBallObstacleBad  = obst_bad_q;
    assign collisionBallBottom       = bottom_q;
    assign collisionBallCredit       = credit_q;
endmodule

// File: tb/tb_collision_event_filter.sv
// tb_collision_event_filter: directed frame sequences with a per-boundary expected-pulse scoreboard.
module tb_collision_event_filter;
    localparam int FL = 48;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0, pause = 1'b0, reset_level_pulse = 1'b0;
    logic rawBallObstacle = 1'b0, rawObstacleGood = 1'b0, rawObstacleBad = 1'b0;
    logic rawBallBottom = 1'b0, rawBallCredit = 1'b0;
    logic collisionBallObstacle, collisionBallObstacleGood, collisionBallObstacleBad;
    logic collisionBallBottom, collisionBallCredit;

    int checks = 0;
    int errors = 0;
    logic run = 1'b0;
    logic sof_seen = 1'b0;
    logic [4:0] exp_q[$];
    logic [4:0] obs, expv;

    always #5 clk = ~clk;

    collision_event_filter #(.COOLDOWN_FRAMES(3)) dut (
        .clk                       (clk),
        .resetN                    (resetN),
        .startOfFrame              (startOfFrame),
        .pause                     (pause),
        .reset_level_pulse         (reset_level_pulse),
        .rawBallObstacle           (rawBallObstacle),
        .rawObstacleGood           (rawObstacleGood),
        .rawObstacleBad            (rawObstacleBad),
        .rawBallBottom             (rawBallBottom),
        .rawBallCredit             (rawBallCredit),
        .collisionBallObstacle     (collisionBallObstacle),
        .collisionBallObstacleGood (collisionBallObstacleGood),
        .collisionBallObstacleBad  (collisionBallObstacleBad),
        .collisionBallBottom       (collisionBallBottom),
        .collisionBallCredit       (collisionBallCredit)
    );

    assign obs = {collisionBallObstacle, collisionBallObstacleGood, collisionBallObstacleBad,
                  collisionBallBottom, collisionBallCredit};

    always @(posedge clk) sof_seen <= startOfFrame;

    // Every cycle is checked: the cycle after a boundary pops its expected pulses, all others must be quiet.
    always @(negedge clk) begin
        if (run) begin
            if (sof_seen) begin
                if (exp_q.size() == 0) begin
                    expv = 5'bxxxxx;
                    checks++;
                    assert (0) else begin
                        errors++;
                        $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
                    end
                end else begin
                    expv = exp_q.pop_front();
                    checks++;
                    assert (obs === expv) else begin
                        errors++;
                        $error("FAIL boundary_pulse t=%0t observed=%b expected=%b", $time, obs, expv);
                    end
                end
            end else begin
                checks++;
                assert (obs === 5'b00000) else begin
                    errors++;
                    $error("FAIL quiet_cycle t=%0t observed=%b expected=00000", $time, obs);
                end
            end
        end
    end

    // raw vector order: {obstacle, good, bad, bottom, credit}; exp is the result of the boundary opening this frame.
    task automatic frame(input logic [4:0] r1, input int n1, input logic [4:0] r2, input int n2,
                         input logic [4:0] exp, input logic fl, input logic pz);
        logic [4:0] r;
        for (int i = 0; i < FL; i++) begin
            r = (i < n1) ? r1 : (i < n1 + n2) ? r2 : 5'b00000;
            startOfFrame = (i == 0);
            reset_level_pulse = fl && (i == 0);
            pause = pz;
            {rawBallObstacle, rawObstacleGood, rawObstacleBad, rawBallBottom, rawBallCredit} = r;
            if (i == 0) exp_q.push_back(exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) frame(5'b0, 0, 5'b0, 0, 5'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset: outputs stay low even with activity and boundaries applied.
        {rawBallObstacle, rawObstacleGood, rawObstacleBad, rawBallBottom, rawBallCredit} = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            startOfFrame = i[0];
            @(posedge clk);
            #1;
            checks++;
            assert (obs === 5'b00000) else begin
                errors++;
                $error("FAIL reset_state observed=%b expected=00000", obs);
            end
        end
        startOfFrame = 1'b0;
        {rawBallObstacle, rawObstacleGood, rawObstacleBad, rawBallBottom, rawBallCredit} = 5'b00000;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b1;

        // Single obstacle contact.
        frame(5'b10000, 40, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b10000, 1'b0, 1'b0);
        idle(4);

        // Continuous contact over five frames.
        frame(5'b10000, FL, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) frame(5'b10000, FL, 5'b0, 0, (k == 0) ? 5'b10000 : 5'b00000, 1'b0, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        idle(4);

        // Contact in frames 1, 3, 5 with cooldown 3: frame 3 is blocked.
        frame(5'b10000, 20, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b10000, 1'b0, 1'b0);
        frame(5'b10000, 20, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        frame(5'b10000, 20, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b10000, 1'b0, 1'b0);
        idle(4);

        // Good with obstacle, bad without obstacle.
        frame(5'b11000, 10, 5'b00100, 10, 5'b00000, 1'b0, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b11000, 1'b0, 1'b0);
        idle(4);

        // Bottom and credit together, then a flush that suppresses a pending obstacle and clears cooldown.
        frame(5'b00011, 10, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        frame(5'b10000, 10, 5'b0, 0, 5'b00011, 1'b0, 1'b0);
        frame(5'b00000, 5, 5'b00011, 10, 5'b00000, 1'b1, 1'b0);
        frame(5'b00000, 0, 5'b0, 0, 5'b00011, 1'b0, 1'b0);
        idle(4);

        // Pause with activity, then release with none.
        for (int k = 0; k < 3; k++) frame(5'b11111, 20, 5'b0, 0, 5'b00000, 1'b0, 1'b1);
        frame(5'b00000, 0, 5'b0, 0, 5'b00000, 1'b0, 1'b0);
        idle(2);

        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        exp_q.push_back(5'b00000);
        @(posedge clk);
        #1;
        run = 1'b0;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/collision_event_filter.md
# collision_event_filter

Converts the raw, pixel-level collision flags produced by the drawing/collision logic into clean, one-shot, frame-aligned events for the game controller. Raw collision flags stay high for every overlapping pixel of a frame, and across consecutive frames while the ball is in contact. This block collapses each contact into exactly one single-cycle pulse per channel, applies a per-channel re-trigger cooldown, and flushes all state on a level restart. It sits directly upstream of `game_controller` and drives its collision inputs.

## Interface
- `COOLDOWN_FRAMES`, default 8: frames during which a channel cannot re-fire after emitting an event (legal range 1–15).
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: single-cycle pulse marking the frame boundary.
- `pause` in 1: game paused; suppresses all events.
- `reset_level_pulse` in 1: level restart; flushes all state.
- `rawBallObstacle` in 1: ball pixel overlaps any obstacle.
- `rawObstacleGood` in 1: overlapped obstacle is of the scoring type.
- `rawObstacleBad` in 1: overlapped obstacle is of the penalty type.
- `rawBallBottom` in 1: ball pixel overlaps the bottom border.
- `rawBallCredit` in 1: ball pixel overlaps a credit object.
- `collisionBallObstacle` out 1: obstacle event pulse.
- `collisionBallObstacleGood` out 1: qualifier, valid only with `collisionBallObstacle`.
- `collisionBallObstacleBad` out 1: qualifier, valid only with `collisionBallObstacle`.
- `collisionBallBottom` out 1: bottom event pulse.
- `collisionBallCredit` out 1: credit event pulse.

## Operation
- Three event channels: OBST, BOTTOM, CREDIT. Each channel holds:
  - frame latch `hit`,
  - previous-frame flag `prev`,
  - 4-bit `cooldown` counter.
- OBST carries two extra qualifier latches, `good` and `bad`.
- Accumulation: in any cycle without `startOfFrame`, `hit |= raw`.
  - `good |= rawBallObstacle & rawObstacleGood`; `bad |= rawBallObstacle & rawObstacleBad`.
  - A good or bad flag without obstacle overlap is ignored.
- Frame boundary (cycle with `startOfFrame`=1, no flush):
  - The snapshot is the latch value before this edge.
  - The channel fires iff snapshot=1, `prev`=0, `cooldown`=0 and `pause`=0.
  - On fire, `cooldown` loads `COOLDOWN_FRAMES`. Otherwise `cooldown` decrements if non-zero (saturates at 0).
  - `prev` ← snapshot.
  - Latches reload with that cycle's raw values; raw data in the `startOfFrame` cycle belongs to the new frame.
- Continuous contact: `prev`=1 blocks re-firing until one frame with snapshot=0 has passed and cooldown has expired.
- OBST qualifiers: output pulses `good`/`bad` = snapshot qualifiers, asserted only in the cycle `collisionBallObstacle` pulses. Both may be high together.
- Simultaneous channels: all channels are independent; several pulses may be high in the same cycle. Priority resolution is left to the controller.
- Pause:
  - Latches are held at 0.
  - Frame boundaries still update `prev` (to 0) and decrement `cooldown`.
  - No output fires.
- Flush (`reset_level_pulse`=1): all latches, `prev`, `cooldown` and outputs clear in the next cycle. Flush beats a coincident `startOfFrame`, so no event is emitted.
- Reset: all state and outputs are 0.

## Timing
- Outputs are registered. A pulse is high for exactly the one cycle after the `startOfFrame` cycle (latency 1 clk from the boundary).
- There is never more than one pulse per channel per frame.
- Minimum spacing between pulses on one channel is `COOLDOWN_FRAMES`+1 frames.
- No combinational path from raw inputs to outputs.
- `resetN` is asynchronous. Deassertion mid-frame starts with empty latches, so the first frame boundary can emit only data seen after reset.

## Structure
- Shared package `defines`:
  - `COLLISION_COOLDOWN_FRAMES`, the default for `COOLDOWN_FRAMES`.
  - An enum of channel indices (OBST, BOTTOM, CREDIT).
- Sub-module `collision_channel`:
  - Contents: latch, `prev`, `cooldown`, fire logic.
  - Instantiated 3 times.
  - OBST qualifier latches stay in the top level.

## Test plan
- OBST raw high for 40 cycles in frame 1, frame 2 clean → `collisionBallObstacle` one pulse in the cycle after the frame-2 `startOfFrame`; no other outputs.
- OBST raw high in frames 1–5 continuously → exactly one pulse, after frame 1.
- Contact in frames 1, 3, 5, with `COOLDOWN_FRAMES`=3 → pulses after frames 1 and 5 only; frame 3 is blocked by cooldown.
- Frame with obstacle+good, and bad seen without obstacle → Obstacle=1, Good=1, Bad=0 in the same cycle.
- Bottom and credit in the same frame → both pulses in the same cycle; flush coincident with the next `startOfFrame` → no pulses; all state is 0 afterwards.
- `pause`=1 with raw activity for 3 frames, then release with no activity → no pulses at any time.
